// File: rtl/axi_lite_master.sv
// axi_lite_master
//   Single-outstanding AXI4-Lite initiator. It turns a simple command/response
//   interface into one AXI4-Lite read or write at a time. Each VALID is held
//   until its handshake. The slave's response, and the read data for reads,
//   come back as a one-cycle rsp_valid pulse.
//
// Handshake rule (all channels): a beat transfers on a rising aclk edge where
//   VALID && READY. The master's VALIDs are driven only from registered state,
//   never combinationally from a READY. Payload is held stable while VALID is high.
//
// Ports
//   aclk, areset        : clock; synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (cmd_ready high only in IDLE)
//   cmd_write/addr/wdata/wstrb : command fields, captured on acceptance
//   rsp_valid           : one-cycle completion pulse
//   rsp_write/resp/rdata: completion info, held until the next completion
//   timeout_err         : sticky watchdog flag (0 when the watchdog is not built)
//   aw*/w*/b*/ar*/r*    : AXI4-Lite master-side channels
//   fsm_state           : current FSM state (debug)
//
// Build option
//   AXI_LITE_MASTER_TIMEOUT_EN : when defined, a wait-cycle counter sets
//   timeout_err after TIMEOUT_CYCLES busy cycles. The transaction continues.
module axi_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  output logic                      rsp_write,
  output logic [1:0]                rsp_resp,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      timeout_err,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [2:0]                fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t state, state_next;
  logic   aw_done, w_done;
  logic   accept;

  assign accept    = cmd_valid && cmd_ready;
  assign fsm_state = state;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awaddr    <= '0;
      araddr    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_resp  <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      state     <= state_next;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (cmd_write) begin
              awaddr <= cmd_addr;
              wdata  <= cmd_wdata;
              wstrb  <= cmd_wstrb;
            end else begin
              araddr <= cmd_addr;
            end
          end
        end
        WR: begin
          // Each channel remembers its own handshake so its VALID drops
          // independently of the other channel.
          if (awvalid && awready) aw_done <= 1'b1;
          if (wvalid && wready)   w_done  <= 1'b1;
        end
        WR_RESP: begin
          if (bvalid) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_resp  <= bresp;
            rsp_rdata <= '0;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_resp  <= rresp;
            rsp_rdata <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    case (state)
      IDLE: begin
        // Held low during reset so no command is taken while areset is high.
        cmd_ready = !areset;
        if (cmd_valid && !areset) state_next = cmd_write ? WR : RD_ADDR;
      end
      WR: begin
        // VALIDs come from state and the registered done flags only.
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_next = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_next = IDLE;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wait_cnt;
  logic          timeout_flag;

  // The counter saturates at LIMIT. The flag is set on the increment that
  // reaches LIMIT, so it is visible right after TIMEOUT_CYCLES busy cycles.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if (state != IDLE && wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == LIMIT_M1) timeout_flag <= 1'b1;
    end
  end

  assign timeout_err = timeout_flag;
`else
  // No watchdog in this build. The parameter is still referenced so both
  // builds share one parameter set. The expression is constant 0.
  assign timeout_err = 1'b0 & (TIMEOUT_CYCLES < 2);
`endif

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: reset state, table-driven
// single transactions against a configurable-latency slave, then hand-written
// back-to-back, long-stall/watchdog and mid-transaction reset sequences.
module tb_axi_lite_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  localparam int TO_EN = 1;
`else
  localparam int TO_EN = 0;
`endif

  logic            aclk, areset;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wstrb;
  logic            rsp_valid, rsp_write;
  logic [1:0]      rsp_resp;
  logic [DW-1:0]   rsp_rdata;
  logic            timeout_err;
  logic [AW-1:0]   awaddr, araddr;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      bresp, rresp;
  logic            arvalid, arready, rvalid, rready;
  logic [2:0]      fsm_state;

  axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_resp(rsp_resp),
    .rsp_rdata(rsp_rdata), .timeout_err(timeout_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  // exp_lat: cycle index (1 = cycle after acceptance edge) in which rsp_valid
  // must pulse, hand-computed from the slave delays.
  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;
    int          w_dly;
    int          ar_dly;
    int          resp_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic drive_idle_slave();
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
  endtask

  // Drives one command and plays the slave with the vector's delays.
  task automatic do_txn(input int idx, input vec_t v);
    int n, rsp_cnt, rsp_k, aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, last_hs, ar_k, proto_err;
    bit aw_done, w_done, b_done, ar_done, r_done;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_wstrb;
    logic        got_write;
    logic [1:0]  got_resp;
    logic [31:0] got_rdata;
    string       p;
    rsp_cnt = 0; rsp_k = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    last_hs = 0; ar_k = 0; proto_err = 0;
    aw_done = 0; w_done = 0; b_done = 0; ar_done = 0; r_done = 0;
    seen_addr = '0; seen_wdata = '0; seen_wstrb = '0;
    got_write = 1'b0; got_resp = 2'b00; got_rdata = '0;
    p = $sformatf("v%0d_", idx);

    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 20) begin
      check({p, "accept"}, 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end

    for (int k = 1; k <= v.exp_lat + 2; k++) begin
      @(negedge aclk);
      if (k == 1) cmd_valid = 1'b0;
      if (b_done) bvalid = 1'b0;
      if (r_done) rvalid = 1'b0;
      if (rsp_valid === 1'b1) begin
        rsp_cnt++; rsp_k = k;
        got_write = rsp_write; got_resp = rsp_resp; got_rdata = rsp_rdata;
      end
      if (cmd_ready !== (k >= v.exp_lat)) proto_err++;
      if ((aw_done && awvalid) || (w_done && wvalid) || (ar_done && arvalid)) proto_err++;
      if ((bready && !(aw_done && w_done)) || (rready && !ar_done)) proto_err++;
      if (v.write) begin
        if (arvalid || rready) proto_err++;
        awready = (k >= 1 + v.aw_dly);
        wready  = (k >= 1 + v.w_dly);
        if (!aw_done && awready && awvalid) begin
          aw_cnt++; seen_addr = awaddr; aw_done = 1; last_hs = k;
        end
        if (!w_done && wready && wvalid) begin
          w_cnt++; seen_wdata = wdata; seen_wstrb = wstrb; w_done = 1; last_hs = k;
        end
        if (aw_done && w_done && !b_done && k >= last_hs + 1 + v.resp_dly) begin
          bvalid = 1'b1; bresp = v.resp;
        end
        if (bvalid && bready) begin
          b_cnt++; b_done = 1;
        end
      end else begin
        if (awvalid || wvalid || bready) proto_err++;
        arready = (k >= 1 + v.ar_dly);
        if (!ar_done && arready && arvalid) begin
          ar_cnt++; seen_addr = araddr; ar_done = 1; ar_k = k;
        end
        if (ar_done && !r_done && k >= ar_k + 1 + v.resp_dly) begin
          rvalid = 1'b1; rresp = v.resp; rdata = v.rdata;
        end
        if (rvalid && rready) begin
          r_cnt++; r_done = 1;
        end
      end
    end
    @(negedge aclk);
    drive_idle_slave();

    check({p, "rsp_count"}, 64'(rsp_cnt), 64'd1);
    check({p, "rsp_cycle"}, 64'(rsp_k), 64'(v.exp_lat));
    check({p, "rsp_write"}, 64'(got_write), 64'(v.write));
    check({p, "rsp_resp"}, 64'(got_resp), 64'(v.resp));
    check({p, "rsp_rdata"}, 64'(got_rdata), 64'(v.exp_rdata));
    check({p, "protocol"}, 64'(proto_err), 64'd0);
    check({p, "addr"}, 64'(seen_addr), 64'(v.addr));
    if (v.write) begin
      check({p, "aw_count"}, 64'(aw_cnt), 64'd1);
      check({p, "w_count"}, 64'(w_cnt), 64'd1);
      check({p, "b_count"}, 64'(b_cnt), 64'd1);
      check({p, "wdata"}, 64'(seen_wdata), 64'(v.wdata));
      check({p, "wstrb"}, 64'(seen_wstrb), 64'(v.wstrb));
    end else begin
      check({p, "ar_count"}, 64'(ar_cnt), 64'd1);
      check({p, "r_count"}, 64'(r_cnt), 64'd1);
    end
    check({p, "rsp_hold_resp"}, 64'(rsp_resp), 64'(v.resp));
    check({p, "rsp_pulse_low"}, 64'(rsp_valid), 64'd0);
    check({p, "timeout_err"}, 64'(timeout_err), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 3, 32'h0};
    vecs[1] = '{1'b0, 32'h24, 32'h0, 4'h0, 0, 0, 2, 0, 2'b10, 32'h12345678, 5, 32'h12345678};
    vecs[2] = '{1'b1, 32'h30, 32'hA5A50001, 4'h3, 3, 0, 0, 0, 2'b10, 32'h0, 6, 32'h0};
    vecs[3] = '{1'b1, 32'h34, 32'h00C0FFEE, 4'hC, 0, 2, 0, 2, 2'b11, 32'h0, 7, 32'h0};
    vecs[4] = '{1'b0, 32'h38, 32'h0, 4'h0, 0, 0, 0, 3, 2'b00, 32'h0BADF00D, 6, 32'h0BADF00D};
    vecs[5] = '{1'b1, 32'h3C, 32'h87654321, 4'h1, 1, 1, 0, 1, 2'b01, 32'h0, 5, 32'h0};

    areset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    drive_idle_slave();

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_valids", 64'({awvalid, wvalid, arvalid}), 64'd0);
    check("rst_readies", 64'({bready, rready}), 64'd0);
    check("rst_rsp", 64'({rsp_valid, rsp_write, rsp_resp}), 64'd0);
    check("rst_regs", 64'(awaddr | araddr | wdata | rsp_rdata | 32'(wstrb)), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    areset = 1'b0;
    @(negedge aclk);
    check("rst_release_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 6; i++) do_txn(i, vecs[i]);

    // Back-to-back: cmd_valid held; second command is a read taken in the
    // rsp_valid cycle of the first.
    @(negedge aclk);
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40;
    cmd_wdata = 32'h11223344; cmd_wstrb = 4'hF;
    check("b2b_ready0", 64'(cmd_ready), 64'd1);
    @(negedge aclk);                                   // k1
    cmd_write = 1'b0; cmd_addr = 32'h44;
    check("b2b_aw_w_valid", 64'({awvalid, wvalid, cmd_ready}), 64'b110);
    @(negedge aclk);                                   // k2
    check("b2b_wr_resp", 64'({awvalid, wvalid, bready}), 64'b001);
    bvalid = 1'b1; bresp = 2'b00;
    @(negedge aclk);                                   // k3
    bvalid = 1'b0;
    check("b2b_rsp1", 64'({rsp_valid, rsp_write, cmd_ready}), 64'b111);
    @(negedge aclk);                                   // k4
    cmd_valid = 1'b0;
    check("b2b_ar", 64'({arvalid, awvalid, wvalid, rsp_valid}), 64'b1000);
    @(negedge aclk);                                   // k5
    check("b2b_rready", 64'({arvalid, rready}), 64'b01);
    check("b2b_araddr", 64'(araddr), 64'h44);
    rvalid = 1'b1; rresp = 2'b01; rdata = 32'hCAFEF00D;
    @(negedge aclk);                                   // k6
    rvalid = 1'b0;
    check("b2b_rsp2", 64'({rsp_valid, rsp_write, rsp_resp}), 64'b1001);
    check("b2b_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
    drive_idle_slave();

    // Long B stall: bvalid withheld for cycles k2..k21.
    @(negedge aclk);
    awready = 1'b1; wready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50;
    cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
    for (int k = 1; k <= 24; k++) begin
      @(negedge aclk);
      if (k == 1) cmd_valid = 1'b0;
      if (k == 8) check("to_before_limit", 64'(timeout_err), 64'd0);
      if (k == 9) check("to_at_limit", 64'(timeout_err), 64'(TO_EN));
      if (k == 21) check("stall_bready", 64'({bready, rsp_valid}), 64'b10);
      if (k == 22) begin bvalid = 1'b1; bresp = 2'b00; end
      if (k == 23) begin
        bvalid = 1'b0;
        check("stall_rsp", 64'({rsp_valid, rsp_write}), 64'b11);
      end
      if (k == 24) check("to_sticky", 64'({timeout_err, rsp_valid}), 64'({TO_EN[0], 1'b0}));
    end
    drive_idle_slave();

    // Reset while awvalid is high; slave withholds ready.
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60;
    cmd_wdata = 32'h5; cmd_wstrb = 4'hF;
    @(negedge aclk);
    cmd_valid = 1'b0;
    check("mid_rst_aw_before", 64'(awvalid), 64'd1);
    areset = 1'b1;
    @(negedge aclk);
    check("mid_rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    check("mid_rst_ready_low", 64'({cmd_ready, rsp_valid, timeout_err}), 64'd0);
    areset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      check($sformatf("post_rst_idle%0d", k), 64'({cmd_ready, rsp_valid, awvalid}), 64'b100);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
